zombie_spawner: RTL and testbench
=================================

Name: zombie_spawner

Overview:
- Writer side of the `place` bus that the dot-matrix displayer reads.
- Owns the 4-lane zombie field: spawns zombies pseudo-randomly, advances them on a periodic step, and clears lanes on kill requests from game logic.
- Reports hits and escapes.
- Sits between game_logic (kill requests, hit/fail bookkeeping) and Dot_matrix_displayer (place).

Parameters:
- STEP_CYCLES, 25_000_000, clock cycles per advance step (minimum 2).
- SPAWN_RATE, 5, spawn succeeds when lfsr[7:5] < SPAWN_RATE (0..8; 8 = always, 0 = never).
- SEED, 8'hA5, LFSR reset value; 8'h00 is replaced by 8'h01.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- run  in  1  game active (driven by ~end_flag); 0 freezes the field
- kill_valid  in  1  one-cycle kill request
- kill_lane  in  2  lane targeted by kill_valid (button index)
- place  out  8  lane i state in place[2i+1:2i]: 00 empty, 01/10/11 zombie stage (11 = at player)
- kill_ack  out  1  one-cycle pulse, the cycle after kill_valid
- kill_hit  out  1  qualifies kill_ack: targeted lane was occupied
- escape  out  1  one-cycle pulse: a stage-11 zombie advanced past the player
- spawn_count  out  8  saturating count of spawns since reset

Behaviour:
- Reset (reset=0, async): place=0, lfsr=SEED (or 01), step counter=0, kill_ack=kill_hit=escape=0, spawn_count=0.
- Step counter:
  - Counts 0..STEP_CYCLES-1 while run=1.
  - step_tick is asserted combinationally in the cycle the counter equals STEP_CYCLES-1; the counter then wraps to 0.
  - run=0 holds the counter value; no ticks occur.
- On step_tick, all lanes update in parallel in one cycle:
  - Occupied lane at 01/10: stage+1.
  - Lane at 11: cleared to 00 and escape=1 for one cycle. Multiple escapes in one tick still give a single pulse.
  - LFSR advances one step (Galois, mask 8'hB8, shift right). The next-state value is used for the spawn decision.
  - Spawn: target lane = lfsr_next[1:0]; spawn when lfsr_next[7:5] < SPAWN_RATE and the target lane is 00 after advance/clear. Target lane is set to 01 and spawn_count increments (saturates at 255).
- Kill:
  - When kill_valid=1, the lane kill_lane is sampled.
  - If occupied and run=1: lane cleared, kill_hit=1.
  - Otherwise: kill_hit=0 and place is unchanged.
  - kill_ack=1 the following cycle in all cases, including run=0.
- Kill and step_tick on the same lane in the same cycle: the kill wins. Lane ends at 00, no advance, no escape from that lane, and no spawn into that lane this tick. Other lanes step normally.
- kill_valid is accepted every cycle. Back-to-back requests each get their own ack. Latency is 1 cycle to ack; place updates at the same edge.
- run falling mid-count: place, lfsr and counter are frozen. On resume, counting continues from the held value.
- All outputs are registered. There is no combinational path from inputs to outputs.

Decomposition:
- Package zombie_pkg holds:
  - lane state encodings (EMPTY=2'b00, STAGE1..STAGE3)
  - NUM_LANES=4
  - LFSR_MASK=8'hB8
  - a helper function for lane-slice extraction.
- Sub-module lfsr8 (enable, seed, 8-bit state output) is instantiated once. All other logic stays in zombie_spawner.

Test Plan:
- Reset release, SEED=8'hA5, STEP_CYCLES=4, SPAWN_RATE=8, run=1 → place=0 until the first tick at cycle 4. Then exactly one lane=01, chosen by lfsr_next[1:0]; spawn_count=1.
- Escape path: force-spawn one zombie, run 3 ticks with no kills → stage goes 01→10→11→00, escape is a single-cycle pulse on the 4th tick, and no other outputs change spuriously.
- Kill hit/miss: lane 2 at 10, kill_valid with kill_lane=2 → next cycle place[5:4]=00, kill_ack=1, kill_hit=1. Repeat on empty lane 0 → kill_ack=1, kill_hit=0, place unchanged.
- Collision: lane 1 at 11, kill on lane 1 in the step_tick cycle → lane 1=00, escape=0, kill_hit=1, lane 1 not respawned that tick.
- Freeze: set run=0 mid-count for 10 cycles with kills → place and spawn_count held, kills acked with kill_hit=0. On run=1, the first tick lands (STEP_CYCLES − held count) cycles later.
- Async reset asserted mid-step with a populated field → all outputs are 0 immediately (no clock edge needed), and the LFSR sequence restarts from SEED.

Source files
------------

// File: rtl/zombie_pkg.sv
// zombie_pkg: shared definitions for the zombie field.
//   - lane state encodings (lane_e)
//   - NUM_LANES, LFSR_MASK
//   - lane_get(): extracts one 2-bit lane from the packed 8-bit place bus
//   - lfsr_next(): one Galois step (shift right, xor mask when bit 0 was set)
package zombie_pkg;

  localparam int NUM_LANES = 4;
  localparam logic [7:0] LFSR_MASK = 8'hB8;

  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    STAGE1 = 2'b01,
    STAGE2 = 2'b10,
    STAGE3 = 2'b11
  } lane_e;

  // Lane i lives in place[2i+1:2i].
  function automatic lane_e lane_get(input logic [7:0] place, input logic [1:0] idx);
    return lane_e'(place[{idx, 1'b0} +: 2]);
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 8'h00);
  endfunction

endpackage

// File: rtl/zombie_spawner_lfsr8.sv
// lfsr8: 8-bit Galois LFSR used as the spawn randomness source.
// Ports:
//   clock   in   system clock
//   reset   in   asynchronous active-low reset, loads SEED (00 becomes 01)
//   enable  in   advance one step at the next edge
//   state   out  current LFSR value
module lfsr8
  import zombie_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  output logic [7:0] state
);

  // An all-zero Galois LFSR never leaves zero, so a zero seed is replaced.
  localparam logic [7:0] RESET_VAL = (SEED == 8'h00) ? 8'h01 : SEED;

  logic [7:0] state_q;
  logic [7:0] state_d;

  always_comb begin
    state_d = state_q;
    if (enable) state_d = lfsr_next(state_q);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= RESET_VAL;
    else        state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/zombie_spawner.sv
// zombie_spawner: owns the 4-lane zombie field and drives the place bus.
// Ports:
//   clock        in   system clock
//   reset        in   asynchronous active-low reset
//   run          in   game active; 0 freezes counter, LFSR and field
//   kill_valid   in   one-cycle kill request
//   kill_lane    in   lane targeted by the kill request
//   place        out  lane i state in place[2i+1:2i] (00 empty, 11 at player)
//   kill_ack     out  pulse one cycle after every kill_valid
//   kill_hit     out  qualifies kill_ack: the targeted lane was occupied
//   escape       out  pulse: at least one stage-3 zombie passed the player
//   spawn_count  out  saturating number of spawns since reset
//
// Kill handshake: kill_valid is a single-cycle request with no backpressure
// (always accepted). Each request is answered by kill_ack exactly one cycle
// later, with kill_hit valid in that same cycle; back-to-back requests get
// back-to-back acks.
module zombie_spawner
  import zombie_pkg::*;
#(
  parameter int         STEP_CYCLES = 25_000_000,
  parameter int         SPAWN_RATE  = 5,
  parameter logic [7:0] SEED        = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic       kill_valid,
  input  logic [1:0] kill_lane,
  output logic [7:0] place,
  output logic       kill_ack,
  output logic       kill_hit,
  output logic       escape,
  output logic [7:0] spawn_count
);

  localparam int CNT_W = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_CYCLES - 1);
  localparam logic [3:0] RATE = 4'(SPAWN_RATE);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       place_q, place_d;
  logic             kill_ack_q, kill_ack_d;
  logic             kill_hit_q, kill_hit_d;
  logic             escape_q, escape_d;
  logic [7:0]       spawn_count_q, spawn_count_d;

  logic             step_tick;
  logic [7:0]       lfsr_state;
  logic [7:0]       lfsr_nx;
  logic [3:0]       kill_mask;
  logic [3:0]       esc_mask;
  logic [1:0]       spawn_lane;
  logic             spawn_ok;
  lane_e            cur_lane;

  lfsr8 #(.SEED(SEED)) u_lfsr (
    .clock  (clock),
    .reset  (reset),
    .enable (step_tick),
    .state  (lfsr_state)
  );

  // The spawn decision uses the value the LFSR will hold after this tick.
  assign lfsr_nx    = lfsr_next(lfsr_state);
  assign spawn_lane = lfsr_nx[1:0];
  assign step_tick  = run && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d         = cnt_q;
    place_d       = place_q;
    spawn_count_d = spawn_count_q;
    kill_mask     = 4'b0000;
    esc_mask      = 4'b0000;
    spawn_ok      = 1'b0;
    cur_lane      = EMPTY;

    if (run) cnt_d = step_tick ? '0 : cnt_q + CNT_W'(1);

    // A kill only lands while running and only on an occupied lane.
    kill_hit_d = kill_valid && run && (lane_get(place_q, kill_lane) != EMPTY);
    kill_ack_d = kill_valid;

    for (int i = 0; i < NUM_LANES; i++) begin
      cur_lane = lane_get(place_q, 2'(i));
      if (kill_hit_d && (kill_lane == 2'(i))) begin
        // Kill beats the step: no advance, no escape from this lane.
        kill_mask[i]      = 1'b1;
        place_d[2*i +: 2] = EMPTY;
      end else if (step_tick) begin
        case (cur_lane)
          STAGE3: begin
            place_d[2*i +: 2] = EMPTY;
            esc_mask[i]       = 1'b1;
          end
          STAGE1:  place_d[2*i +: 2] = STAGE2;
          STAGE2:  place_d[2*i +: 2] = STAGE3;
          default: place_d[2*i +: 2] = EMPTY;
        endcase
      end
    end

    // Spawn checks the lane after advance/clear, and never refills a lane
    // that was just killed on this tick.
    spawn_ok = step_tick
            && ({1'b0, lfsr_nx[7:5]} < RATE)
            && !kill_mask[spawn_lane]
            && (lane_get(place_d, spawn_lane) == EMPTY);
    if (spawn_ok) begin
      place_d[{spawn_lane, 1'b0} +: 2] = STAGE1;
      if (spawn_count_q != 8'hFF) spawn_count_d = spawn_count_q + 8'd1;
    end

    escape_d = |esc_mask;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q         <= '0;
      place_q       <= 8'h00;
      kill_ack_q    <= 1'b0;
      kill_hit_q    <= 1'b0;
      escape_q      <= 1'b0;
      spawn_count_q <= 8'h00;
    end else begin
      cnt_q         <= cnt_d;
      place_q       <= place_d;
      kill_ack_q    <= kill_ack_d;
      kill_hit_q    <= kill_hit_d;
      escape_q      <= escape_d;
      spawn_count_q <= spawn_count_d;
    end
  end

  assign place       = place_q;
  assign kill_ack    = kill_ack_q;
  assign kill_hit    = kill_hit_q;
  assign escape      = escape_q;
  assign spawn_count = spawn_count_q;

endmodule

// File: tb/tb_zombie_spawner.sv
// Bench for zombie_spawner: two instances (SPAWN_RATE 8 and 5, STEP_CYCLES 4,
// SEED A5) share one randomized stimulus stream and are compared every cycle
// against a lane-array reference model.
module tb_zombie_spawner;

  localparam int STEP = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0;
  logic       kill_valid = 1'b0;
  logic [1:0] kill_lane = 2'd0;

  logic [7:0] place_o [2];
  logic       ack_o   [2];
  logic       hit_o   [2];
  logic       esc_o   [2];
  logic [7:0] cnt_o   [2];

  int n_vec = 0;
  int n_err = 0;

  // Reference model state, index 0 = rate 8, index 1 = rate 5.
  int rate [2] = '{8, 5};
  int m_lane [2][4];
  int m_cnt  [2];
  int m_lfsr [2];
  int m_spawns [2];
  bit e_ack;
  bit e_hit [2];
  bit e_esc [2];

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  zombie_spawner #(.STEP_CYCLES(STEP), .SPAWN_RATE(8), .SEED(8'hA5)) u_dut0 (
    .clock(clock), .reset(reset), .run(run), .kill_valid(kill_valid),
    .kill_lane(kill_lane), .place(place_o[0]), .kill_ack(ack_o[0]),
    .kill_hit(hit_o[0]), .escape(esc_o[0]), .spawn_count(cnt_o[0])
  );

  zombie_spawner #(.STEP_CYCLES(STEP), .SPAWN_RATE(5), .SEED(8'hA5)) u_dut1 (
    .clock(clock), .reset(reset), .run(run), .kill_valid(kill_valid),
    .kill_lane(kill_lane), .place(place_o[1]), .kill_ack(ack_o[1]),
    .kill_hit(hit_o[1]), .escape(esc_o[1]), .spawn_count(cnt_o[1])
  );

  // ---------------- reference model ----------------
  function automatic int lfsr_adv(input int s);
    return (s >> 1) ^ (((s & 1) != 0) ? 'hB8 : 0);
  endfunction

  function automatic logic [7:0] m_place(input int m);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 4; i++) p = p | 8'(m_lane[m][i] << (2 * i));
    return p;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 4; i++) m_lane[m][i] = 0;
      m_cnt[m] = 0; m_lfsr[m] = 'hA5; m_spawns[m] = 0;
      e_hit[m] = 0; e_esc[m] = 0;
    end
    e_ack = 0;
  endtask

  task automatic model_step(input bit r, input bit kv, input int kl);
    int nl [4];
    bit tick, hit, esc;
    int tgt;
    for (int m = 0; m < 2; m++) begin
      tick = r && (m_cnt[m] == STEP - 1);
      hit  = kv && r && (m_lane[m][kl] != 0);
      esc  = 0;
      for (int i = 0; i < 4; i++) nl[i] = m_lane[m][i];
      if (hit) nl[kl] = 0;
      if (tick) begin
        for (int i = 0; i < 4; i++) begin
          if (!(hit && i == kl)) begin
            if (m_lane[m][i] == 3) begin nl[i] = 0; esc = 1; end
            else if (m_lane[m][i] != 0) nl[i] = m_lane[m][i] + 1;
          end
        end
        m_lfsr[m] = lfsr_adv(m_lfsr[m]);
        tgt = m_lfsr[m] % 4;
        if ((m_lfsr[m] / 32) < rate[m] && !(hit && tgt == kl) && nl[tgt] == 0) begin
          nl[tgt] = 1;
          if (m_spawns[m] < 255) m_spawns[m]++;
        end
      end
      if (r) m_cnt[m] = tick ? 0 : m_cnt[m] + 1;
      for (int i = 0; i < 4; i++) m_lane[m][i] = nl[i];
      e_hit[m] = hit;
      e_esc[m] = esc;
    end
    e_ack = kv;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("place[%0d]", m), place_o[m], m_place(m));
      chk($sformatf("kill_ack[%0d]", m), 8'(ack_o[m]), 8'(e_ack));
      chk($sformatf("kill_hit[%0d]", m), 8'(hit_o[m]), 8'(e_hit[m]));
      chk($sformatf("escape[%0d]", m), 8'(esc_o[m]), 8'(e_esc[m]));
      chk($sformatf("spawn_count[%0d]", m), cnt_o[m], 8'(m_spawns[m]));
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 time unit after an edge; outputs are sampled 1 unit after
  // the next edge, once the model has absorbed the same inputs.
  task automatic apply(input bit r, input bit kv, input int kl);
    run = r; kill_valid = kv; kill_lane = 2'(kl);
    @(posedge clock);
    model_step(r, kv, kl);
    #1;
    n_vec++;
    check_all();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] held_place [2];
    logic [7:0] held_cnt   [2];
    bit found;
    int kl;

    model_reset();
    #12;
    check_all();                       // reset state
    @(posedge clock); #1 reset = 1'b1;

    // First tick at the 4th running edge: LFSR A5 -> EA, lane 2 spawns only
    // at rate 8 (EA[7:5]=7 is not below 5).
    for (int c = 0; c < STEP; c++) apply(1, 0, 0);
    chk("first_spawn_place_r8", place_o[0], 8'h10);
    chk("first_spawn_count_r8", cnt_o[0], 8'h01);
    chk("first_spawn_place_r5", place_o[1], 8'h00);

    // Escape path: let zombies walk with no kills.
    for (int c = 0; c < 40; c++) apply(1, 0, 0);

    // Random kills while running.
    for (int c = 0; c < 150; c++)
      apply(1, ($urandom_range(0, 1) == 1), int'($urandom_range(0, 3)));

    // Freeze mid-count with kills: nothing moves, kills ack with hit=0.
    apply(1, 0, 0);
    for (int m = 0; m < 2; m++) begin held_place[m] = place_o[m]; held_cnt[m] = cnt_o[m]; end
    for (int c = 0; c < 10; c++) apply(0, 1, int'($urandom_range(0, 3)));
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("freeze_place[%0d]", m), place_o[m], held_place[m]);
      chk($sformatf("freeze_count[%0d]", m), cnt_o[m], held_cnt[m]);
    end
    for (int c = 0; c < 8; c++) apply(1, 0, 0);

    // Collision: kill a stage-3 lane exactly in the tick cycle.
    found = 0;
    for (int c = 0; c < 400 && !found; c++) begin
      kl = -1;
      if (m_cnt[0] == STEP - 1)
        for (int i = 0; i < 4; i++) if (m_lane[0][i] == 3) kl = i;
      if (kl >= 0) begin
        apply(1, 1, kl);
        found = 1;
        chk("collision_hit", 8'(hit_o[0]), 8'h01);
        chk("collision_lane", 8'((place_o[0] >> (2 * kl)) & 8'h03), 8'h00);
      end else begin
        apply(1, 0, 0);
      end
    end
    chk("collision_found", 8'(found), 8'h01);

    // Random run and kills.
    for (int c = 0; c < 200; c++)
      apply(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
            int'($urandom_range(0, 3)));

    // Async reset mid-step with a populated field.
    for (int c = 0; c < 14; c++) apply(1, 0, 0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    n_vec++;
    check_all();                       // outputs clear with no clock edge
    @(posedge clock); #1 reset = 1'b1;
    for (int c = 0; c < STEP; c++) apply(1, 0, 0);
    chk("restart_place_r8", place_o[0], 8'h10);
    chk("restart_count_r8", cnt_o[0], 8'h01);
    for (int c = 0; c < 30; c++)
      apply(1, ($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
